axi4_sram_slave: RTL and testbench

AXI4 slave responder that is the memory-side counterpart to the ALU CPU master. It accepts AW/W/B writes and AR/R reads into an internal word-addressed SRAM array. Single outstanding transaction per direction; supports FIXED and INCR bursts up to 256 beats. Sits behind the interconnect as the operand/result memory for the ALU master.

---
 rtl/axi_slave_pkg.sv | 23 ++
 rtl/axi_sram_burst_addr.sv | 33 +++
 rtl/axi4_sram_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_axi4_sram_slave.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_pkg.sv
// Shared encodings for the AXI4 SRAM slave: response codes,
// burst types and the write/read channel state machines.
package axi_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

endpackage

// File: rtl/axi_sram_burst_addr.sv
// Per-beat burst address step, window range check and last-beat
// detection; one instance serves each channel.
module axi_sram_burst_addr
    import axi_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            burst,
    input  logic [7:0]            cnt,
    input  logic [7:0]            len,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  ok,
    output logic                  last,
    output logic [IDX_W-1:0]      idx
);

    localparam logic [ADDR_WIDTH-1:0] WIN = ADDR_WIDTH'(4 * MEM_DEPTH);

    logic [ADDR_WIDTH-1:0] offset;

    // Addresses below the base wrap to a huge offset and fail too.
    assign offset    = addr - BASE_ADDR;
    assign ok        = (offset < WIN) && (burst != BURST_WRAP);
    assign idx       = offset[IDX_W+1:2];
    assign last      = (cnt == len);
    assign next_addr = (burst == BURST_FIXED) ? addr
                                              : addr + ADDR_WIDTH'(4);

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 slave over a word-addressed SRAM, one burst per direction.
// Define AXI_SLAVE_STALL_EN to insert LFSR-driven W/R backpressure.
module axi4_sram_slave
    import axi_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
    input  logic [7:0]              S_AXI_awlen,
    input  logic [1:0]              S_AXI_awburst,
    input  logic                    S_AXI_awvalid,
    output logic                    S_AXI_awready,
    input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
    input  logic                    S_AXI_wlast,
    input  logic                    S_AXI_wvalid,
    output logic                    S_AXI_wready,
    output logic [1:0]              S_AXI_bresp,
    output logic                    S_AXI_bvalid,
    input  logic                    S_AXI_bready,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
    input  logic [7:0]              S_AXI_arlen,
    input  logic [1:0]              S_AXI_arburst,
    input  logic                    S_AXI_arvalid,
    output logic                    S_AXI_arready,
    output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
    output logic [1:0]              S_AXI_rresp,
    output logic                    S_AXI_rlast,
    output logic                    S_AXI_rvalid,
    input  logic                    S_AXI_rready
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int NB    = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  go;

`ifdef AXI_SLAVE_STALL_EN
    logic [7:0] lfsr;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) lfsr <= 8'hA5;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign go = lfsr[0];
`else
    assign go = 1'b1;
`endif

    w_state_e              w_state, w_next;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len, w_cnt;
    logic [1:0]            aw_burst;
    logic                  w_err, awready_q, wready_q, bvalid_q;
    logic                  aw_fire, w_fire;
    logic [ADDR_WIDTH-1:0] w_nxt_addr;
    logic                  w_ok, w_last;
    logic [IDX_W-1:0]      w_idx;

    assign S_AXI_awready = awready_q;
    assign S_AXI_wready  = wready_q & go;
    assign S_AXI_bvalid  = bvalid_q;
    assign S_AXI_bresp   = w_err ? RESP_SLVERR : RESP_OKAY;
    assign aw_fire       = S_AXI_awvalid & awready_q;
    assign w_fire        = S_AXI_wvalid & S_AXI_wready;

    axi_sram_burst_addr #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_waddr (
        .addr     (aw_addr),
        .burst    (aw_burst),
        .cnt      (w_cnt),
        .len      (aw_len),
        .next_addr(w_nxt_addr),
        .ok       (w_ok),
        .last     (w_last),
        .idx      (w_idx)
    );

    always_comb begin
        w_next = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_fire)          w_next = W_DATA;
            W_DATA:  if (w_fire && w_last) w_next = W_RESP;
            W_RESP:  if (S_AXI_bready)     w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            aw_addr   <= '0;
            aw_len    <= '0;
            aw_burst  <= '0;
            w_cnt     <= '0;
            w_err     <= 1'b0;
        end else begin
            w_state   <= w_next;
            awready_q <= (w_next == W_IDLE);
            wready_q  <= (w_next == W_DATA);
            bvalid_q  <= (w_next == W_RESP);
            if (aw_fire) begin
                aw_addr  <= S_AXI_awaddr;
                aw_len   <= S_AXI_awlen;
                aw_burst <= S_AXI_awburst;
                w_cnt    <= '0;
                w_err    <= 1'b0;
            end else if (w_fire) begin
                aw_addr <= w_nxt_addr;
                w_cnt   <= w_cnt + 8'd1;
                if (!w_ok || (S_AXI_wlast != w_last)) w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_fire && w_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (S_AXI_wstrb[b]) mem[w_idx][8*b +: 8] <= S_AXI_wdata[8*b +: 8];
            end
        end
    end

    r_state_e              r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr, r_cur_addr, r_nxt_addr;
    logic [7:0]            r_len, r_cnt, r_cur_len, r_cur_cnt;
    logic [1:0]            r_burst, r_cur_burst, rresp_q;
    logic                  r_done, arready_q, rvalid_q, rlast_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  r_idle, ar_fire, r_load, r_ok, r_last;
    logic [IDX_W-1:0]      r_idx;

    assign S_AXI_arready = arready_q;
    assign S_AXI_rvalid  = rvalid_q;
    assign S_AXI_rdata   = rdata_q;
    assign S_AXI_rresp   = rresp_q;
    assign S_AXI_rlast   = rlast_q;
    assign r_idle        = (r_state == R_IDLE);
    assign ar_fire       = S_AXI_arvalid & arready_q;

    // Beat 0 is fetched straight off the AR bus so it lands next cycle.
    assign r_cur_addr  = r_idle ? S_AXI_araddr  : r_addr;
    assign r_cur_len   = r_idle ? S_AXI_arlen   : r_len;
    assign r_cur_burst = r_idle ? S_AXI_arburst : r_burst;
    assign r_cur_cnt   = r_idle ? 8'd0          : r_cnt;
    assign r_load      = go & (r_idle ? ar_fire
                                      : (!r_done && (!rvalid_q || S_AXI_rready)));

    axi_sram_burst_addr #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_DEPTH (MEM_DEPTH),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_raddr (
        .addr     (r_cur_addr),
        .burst    (r_cur_burst),
        .cnt      (r_cur_cnt),
        .len      (r_cur_len),
        .next_addr(r_nxt_addr),
        .ok       (r_ok),
        .last     (r_last),
        .idx      (r_idx)
    );

    always_comb begin
        r_next = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_fire) r_next = R_DATA;
            R_DATA:  if (rvalid_q && S_AXI_rready && rlast_q) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            rlast_q   <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_burst   <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= r_next;
            arready_q <= (r_next == R_IDLE);
            if (ar_fire) begin
                r_addr  <= S_AXI_araddr;
                r_len   <= S_AXI_arlen;
                r_burst <= S_AXI_arburst;
                r_cnt   <= '0;
                r_done  <= 1'b0;
            end
            if (r_load) begin
                r_addr   <= r_nxt_addr;
                r_cnt    <= r_cur_cnt + 8'd1;
                r_done   <= r_last;
                rdata_q  <= r_ok ? mem[r_idx] : '0;
                rresp_q  <= r_ok ? RESP_OKAY : RESP_SLVERR;
                rlast_q  <= r_last;
                rvalid_q <= 1'b1;
            end else if (rvalid_q && S_AXI_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave: bursts, strobes, range/WRAP
// errors, wlast mismatch, R backpressure and reset mid-burst.
module tb_axi4_sram_slave;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] wbuf    [0:15];
    logic [31:0] rb_data [0:15];
    logic [1:0]  rb_resp [0:15];
    logic        rb_last [0:15];
    logic [1:0]  resp;

    always #5 ACLK = ~ACLK;

    axi4_sram_slave dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .S_AXI_awaddr (awaddr),
        .S_AXI_awlen  (awlen),
        .S_AXI_awburst(awburst),
        .S_AXI_awvalid(awvalid),
        .S_AXI_awready(awready),
        .S_AXI_wdata  (wdata),
        .S_AXI_wstrb  (wstrb),
        .S_AXI_wlast  (wlast),
        .S_AXI_wvalid (wvalid),
        .S_AXI_wready (wready),
        .S_AXI_bresp  (bresp),
        .S_AXI_bvalid (bvalid),
        .S_AXI_bready (bready),
        .S_AXI_araddr (araddr),
        .S_AXI_arlen  (arlen),
        .S_AXI_arburst(arburst),
        .S_AXI_arvalid(arvalid),
        .S_AXI_arready(arready),
        .S_AXI_rdata  (rdata),
        .S_AXI_rresp  (rresp),
        .S_AXI_rlast  (rlast),
        .S_AXI_rvalid (rvalid),
        .S_AXI_rready (rready)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] bu);
        bit hs = 0;
        araddr  = a;
        arlen   = len;
        arburst = bu;
        arvalid = 1'b1;
        for (int k = 0; k < 100 && !hs; k++) begin
            hs = arready;
            tick();
        end
        arvalid = 1'b0;
        check("ar_hs", 32'(hs), 1);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [7:0] len,
                             input logic [1:0] bu, input logic [3:0] st,
                             input int last_at, output logic [1:0] rsp);
        bit hs = 0;
        awaddr  = a;
        awlen   = len;
        awburst = bu;
        awvalid = 1'b1;
        for (int k = 0; k < 100 && !hs; k++) begin
            hs = awready;
            tick();
        end
        awvalid = 1'b0;
        check("aw_hs", 32'(hs), 1);
        for (int i = 0; i <= int'(len); i++) begin
            wdata  = wbuf[i];
            wstrb  = st;
            wlast  = (i == last_at);
            wvalid = 1'b1;
            hs = 0;
            for (int k = 0; k < 100 && !hs; k++) begin
                hs = wready;
                tick();
            end
            if (!hs) check("w_hs", 32'(hs), 1);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        bready = 1'b1;
        rsp    = 2'b11;
        hs     = 0;
        for (int k = 0; k < 100 && !hs; k++) begin
            if (bvalid) begin
                hs  = 1;
                rsp = bresp;
            end
            tick();
        end
        bready = 1'b0;
        check("b_hs", 32'(hs), 1);
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [7:0] len,
                            input logic [1:0] bu, input bit tog);
        int n = 0;
        bit held = 0;
        logic [31:0] hd = '0;
        ar_send(a, len, bu);
        for (int k = 0; k < 400 && n <= int'(len); k++) begin
            rready = tog ? k[0] : 1'b1;
            if (rvalid) begin
                if (held) check("r_hold", rdata, hd);
                if (rready) begin
                    rb_data[n] = rdata;
                    rb_resp[n] = rresp;
                    rb_last[n] = rlast;
                    n++;
                    held = 0;
                end else begin
                    held = 1;
                    hd   = rdata;
                end
            end
            tick();
        end
        rready = 1'b0;
        check("r_beats", 32'(n), 32'(len) + 1);
    endtask

    initial begin
        int n;
        // reset state
        tick();
        tick();
        check("rst_awready", 32'(awready), 0);
        check("rst_arready", 32'(arready), 0);
        check("rst_wready", 32'(wready), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        ARESET = 1'b0;
        tick();
        check("rel_awready", 32'(awready), 1);
        check("rel_arready", 32'(arready), 1);

        // single beat
        wbuf[0] = 32'hDEADBEEF;
        axi_write(32'h10, 0, 2'b01, 4'hF, 0, resp);
        check("t1_bresp", 32'(resp), 0);
        axi_read(32'h10, 0, 2'b01, 0);
        check("t1_rdata", rb_data[0], 32'hDEADBEEF);
        check("t1_rlast", 32'(rb_last[0]), 1);
        check("t1_rresp", 32'(rb_resp[0]), 0);

        // INCR len3 with toggled rready
        for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
        axi_write(32'h20, 3, 2'b01, 4'hF, 3, resp);
        check("t2_bresp", 32'(resp), 0);
        axi_read(32'h20, 3, 2'b01, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_d%0d", i), rb_data[i], 32'(i + 1));
            check($sformatf("t2_l%0d", i), 32'(rb_last[i]), 32'(i == 3));
        end

        // crossing the window end
        wbuf[0] = 32'hAAAA0001;
        wbuf[1] = 32'hAAAA0002;
        axi_write(32'h3FC, 1, 2'b01, 4'hF, 1, resp);
        check("t3_bresp", 32'(resp), 2);
        axi_read(32'h3FC, 1, 2'b01, 0);
        check("t3_d0", rb_data[0], 32'hAAAA0001);
        check("t3_r0", 32'(rb_resp[0]), 0);
        check("t3_d1", rb_data[1], 32'h0);
        check("t3_r1", 32'(rb_resp[1]), 2);
        check("t3_l1", 32'(rb_last[1]), 1);

        // byte strobes
        wbuf[0] = 32'h12345678;
        axi_write(32'h50, 0, 2'b01, 4'hF, 0, resp);
        wbuf[0] = 32'hAAAA5555;
        axi_write(32'h50, 0, 2'b01, 4'b0011, 0, resp);
        check("t4_bresp", 32'(resp), 0);
        axi_read(32'h50, 0, 2'b01, 0);
        check("t4_rdata", rb_data[0], 32'h12345555);

        // FIXED burst
        for (int i = 0; i < 3; i++) wbuf[i] = 32'(i + 7);
        axi_write(32'h40, 2, 2'b00, 4'hF, 2, resp);
        check("t5_bresp", 32'(resp), 0);
        axi_read(32'h40, 0, 2'b01, 0);
        check("t5_rdata", rb_data[0], 32'd9);

        // early wlast still consumes all beats
        axi_write(32'h60, 2, 2'b01, 4'hF, 1, resp);
        check("t6_bresp", 32'(resp), 2);

        // WRAP rejected on both channels
        wbuf[0] = 32'h11111111;
        axi_write(32'h70, 0, 2'b01, 4'hF, 0, resp);
        wbuf[0] = 32'h22222222;
        axi_write(32'h70, 0, 2'b10, 4'hF, 0, resp);
        check("t7_wresp", 32'(resp), 2);
        axi_read(32'h70, 0, 2'b01, 0);
        check("t7_keep", rb_data[0], 32'h11111111);
        axi_read(32'h70, 0, 2'b10, 0);
        check("t7_rdata", rb_data[0], 32'h0);
        check("t7_rresp", 32'(rb_resp[0]), 2);

        // reset during a len7 read
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h100 + 32'(i);
        axi_write(32'h80, 7, 2'b01, 4'hF, 7, resp);
        ar_send(32'h80, 7, 2'b01);
        rready = 1'b1;
        n = 0;
        for (int k = 0; k < 200 && n < 3; k++) begin
            if (rvalid) n++;
            tick();
        end
        check("t8_beats", 32'(n), 3);
        ARESET = 1'b1;
        #1;
        check("t8_rvalid", 32'(rvalid), 0);
        rready = 1'b0;
        tick();
        ARESET = 1'b0;
        check("t8_arready0", 32'(arready), 0);
        tick();
        check("t8_arready1", 32'(arready), 1);
        axi_read(32'h80, 7, 2'b01, 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("t8_d%0d", i), rb_data[i], 32'h100 + 32'(i));
        axi_read(32'h10, 0, 2'b01, 0);
        check("t8_keep", rb_data[0], 32'hDEADBEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
